key_reset_sequencer: RTL

Board-level front end that turns the raw active-low push-button into a clean system reset request for the PLL/clock-generator reset input. It also produces debounced key status for the rest of the design. A long press forces a full system reset, which is held until the key is released plus a fixed hold time. A power-on reset of fixed length is generated after the async reset releases.

---
 rtl/key_reset_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/key_reset_sequencer.sv
// Push-button front end: synchronises and debounces the raw key, flags press and
// long-press events, and sequences the system reset for the clock generator.
module key_reset_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 200000000,
  parameter int unsigned HOLD_CYCLES     = 100000
) (
  input  logic sys_clk_pad_i,
  input  logic rst_n_pad_i,
  input  logic key_n_pad_i,
  output logic rst_n_o,
  output logic key_o,
  output logic key_press_o,
  output logic key_long_o
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LONG_W = $clog2(LONG_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_POR     = 2'd0,
    ST_RUN     = 2'd1,
    ST_KEY_RST = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  logic              key_meta;
  logic              key_sync;
  logic [DEB_W-1:0]  deb_cnt;
  logic [LONG_W-1:0] long_cnt;
  logic              long_armed;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_nxt;
  state_t            state;
  state_t            state_nxt;
  logic              rst_n_nxt;

  logic key_differs_c;
  logic deb_done_c;
  logic key_rise_c;
  logic key_fall_c;
  logic long_hit_c;
  logic hold_last_c;

  // Two-flop synchroniser; idles at the released level
  always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key_n_pad_i;
      key_sync <= key_meta;
    end
  end

  assign key_differs_c = (~key_sync) != key_o;
  assign deb_done_c    = key_differs_c && (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1));
  assign key_rise_c    = deb_done_c && !key_o;
  assign key_fall_c    = deb_done_c && key_o;

  // Debounce: stable level flips only after an unbroken run of disagreement
  always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      deb_cnt     <= '0;
      key_o       <= 1'b0;
      key_press_o <= 1'b0;
    end else begin
      key_press_o <= key_rise_c;
      if (!key_differs_c) begin
        deb_cnt <= '0;
      end else if (deb_done_c) begin
        deb_cnt <= '0;
        key_o   <= ~key_o;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  assign long_hit_c = key_o && (long_cnt == LONG_W'(LONG_CYCLES - 1));

  // Long-press timer saturates so the pulse fires once per press
  always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      long_cnt   <= '0;
      key_long_o <= 1'b0;
    end else begin
      key_long_o <= long_hit_c;
      if (!key_o) begin
        long_cnt <= '0;
      end else if (long_cnt != LONG_W'(LONG_CYCLES)) begin
        long_cnt <= long_cnt + LONG_W'(1);
      end
    end
  end

  // A press may only force a reset if it began while the system was running
  always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      long_armed <= 1'b0;
    end else if (key_rise_c) begin
      long_armed <= (state == ST_RUN);
    end else if (!key_o) begin
      long_armed <= 1'b0;
    end
  end

  assign hold_last_c = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

  always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      state    <= ST_POR;
      hold_cnt <= '0;
      rst_n_o  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      rst_n_o  <= rst_n_nxt;
    end
  end

  // The release strobe lets HOLD start on the same edge key_o falls
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    unique case (state)
      ST_POR, ST_HOLD: begin
        if (hold_last_c) begin
          state_nxt    = ST_RUN;
          hold_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (key_long_o && long_armed) begin
          state_nxt = ST_KEY_RST;
        end
      end
      ST_KEY_RST: begin
        if (!key_o || key_fall_c) begin
          state_nxt    = ST_HOLD;
          hold_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = ST_POR;
        hold_cnt_nxt = '0;
      end
    endcase
    rst_n_nxt = (state_nxt == ST_RUN);
  end

endmodule
